tlul_err_chk_resp: RTL

Parametrised TL-UL A-channel legality checker and in-line error responder for 32- or 64-bit buses.
- Forwards legal requests downstream and absorbs illegal ones.
- Returns an in-order D-channel error response for each absorbed request.
- Maintains a sticky first-error record and a saturating error counter.
- Sits in front of a device port; an external D mux merges err_d_* with the downstream D channel.

---
 rtl/tlul_err_chk_resp.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlul_err_chk_resp.sv
`default_nettype none
// ============================================================================
// Module   : tlul_err_chk_resp
// Purpose  : TL-UL A-channel legality checker with in-line error responder.
//            Legal requests pass straight through to the device port. Illegal
//            requests are absorbed and answered with an in-order D-channel
//            error response. Before an illegal request is accepted, every
//            forwarded request must have drained, which keeps the responses
//            in order.
//            An external D mux merges err_d_* with the device D channel.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Build option:
//   TLUL_ERR_CHK_STATS_EN  defined   -> saturating error counter plus a
//                                       first-error address/cause capture
//                          undefined -> err_cnt_o/err_addr_o/err_cause_o tied
//                                       to 0, err_clr_i ignored
// ----------------------------------------------------------------------------
// Parameters:
//   AW      address width
//   DW      data width, 32 or 64
//   IW      a_source width
//   SZW     a_size width
//   MaxOut  max outstanding forwarded requests (>= 1)
//   CntW    error counter width
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   a_valid_i/a_ready_o   host A handshake
//   a_opcode_i            0 PutFullData, 1 PutPartialData, 4 Get
//   a_size_i              log2 of transfer bytes
//   a_source_i            source ID
//   a_address_i           byte address
//   a_mask_i              byte lane mask
//   a_valid_o/a_ready_i   forwarded A handshake to the device
//   dn_d_valid_i          device D valid (observed only)
//   dn_d_ready_i          host ready for device D (observed only)
//   err_d_valid_o         error response valid
//   err_d_ready_i         host ready for the error response
//   err_d_opcode_o        0 AccessAck, 1 AccessAckData
//   err_d_source_o        echoed source
//   err_d_size_o          echoed size
//   err_d_error_o         1 while err_d_valid_o
//   err_d_data_o          all ones
//   err_cnt_o             saturating illegal-request count
//   err_addr_o            address of the first illegal request since clear
//   err_cause_o           {opcode_bad, align_bad, mask_bad} of that request
//   err_clr_i             clears the counter and the capture
// ============================================================================
module tlul_err_chk_resp #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int IW     = 8,
   parameter int SZW    = 2,
   parameter int MaxOut = 4,
   parameter int CntW   = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            a_valid_i,
   output logic            a_ready_o,
   input  logic [2:0]      a_opcode_i,
   input  logic [SZW-1:0]  a_size_i,
   input  logic [IW-1:0]   a_source_i,
   input  logic [AW-1:0]   a_address_i,
   input  logic [DW/8-1:0] a_mask_i,
   output logic            a_valid_o,
   input  logic            a_ready_i,
   input  logic            dn_d_valid_i,
   input  logic            dn_d_ready_i,
   output logic            err_d_valid_o,
   input  logic            err_d_ready_i,
   output logic [2:0]      err_d_opcode_o,
   output logic [IW-1:0]   err_d_source_o,
   output logic [SZW-1:0]  err_d_size_o,
   output logic            err_d_error_o,
   output logic [DW-1:0]   err_d_data_o,
   output logic [CntW-1:0] err_cnt_o,
   output logic [AW-1:0]   err_addr_o,
   output logic [2:0]      err_cause_o,
   input  logic            err_clr_i
);

   localparam int BW  = DW / 8;           // bytes per beat
   localparam int MB  = $clog2(BW);       // byte-offset bits within a beat
   localparam int OCW = $clog2(MaxOut + 1);

   localparam logic [OCW-1:0] c_max_out    = OCW'(MaxOut);
   localparam logic [2:0]     c_op_put_full = 3'd0;
   localparam logic [2:0]     c_op_put_part = 3'd1;
   localparam logic [2:0]     c_op_get      = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // -------------------------------------------------------------------------
   // Legality decode (purely combinational on the A inputs)
   // -------------------------------------------------------------------------
   logic [MB-1:0] w_off;
   logic [BW-1:0] w_lanes;
   logic          w_opcode_bad;
   logic          w_align_bad;
   logic          w_mask_bad;
   logic          w_illegal;

   assign w_off = a_address_i[MB-1:0];

   // Lanes covered by the transfer: 2^size bytes starting at the beat offset.
   // Bits above the beat are dropped; such requests are align_bad anyway.
   always_comb begin
      w_lanes = '0;
      for (int b = 0; b < BW; b++) begin
         if ((b >= int'(w_off)) && (b < (int'(w_off) + (1 << a_size_i)))) begin
            w_lanes[b] = 1'b1;
         end
      end
   end

   assign w_opcode_bad = !((a_opcode_i == c_op_put_full) ||
                           (a_opcode_i == c_op_put_part) ||
                           (a_opcode_i == c_op_get));

   assign w_align_bad  = (int'(a_size_i) > MB) ||
                         ((int'(w_off) & ((1 << a_size_i) - 1)) != 0);

   assign w_mask_bad   = (|(a_mask_i & ~w_lanes)) ||
                         ((a_opcode_i == c_op_put_full) && (a_mask_i != w_lanes));

   assign w_illegal    = w_opcode_bad | w_align_bad | w_mask_bad;

   // -------------------------------------------------------------------------
   // Outstanding forwarded-request counter
   // -------------------------------------------------------------------------
   logic [OCW-1:0] r_oc;
   logic           w_fwd_hs;
   logic           w_dn_hs;
   logic           w_oc_zero;
   logic           w_room;

   assign w_fwd_hs  = a_valid_o & a_ready_i;
   assign w_dn_hs   = dn_d_valid_i & dn_d_ready_i;
   assign w_oc_zero = (r_oc == '0);
   assign w_room    = (r_oc < c_max_out);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_oc <= '0;
      end else if (w_fwd_hs && !w_dn_hs) begin
         r_oc <= r_oc + 1'b1;
      end else if (w_dn_hs && !w_fwd_hs && !w_oc_zero) begin
         r_oc <= r_oc - 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM
   // -------------------------------------------------------------------------
   logic w_err_accept;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      a_ready_o    = 1'b0;
      a_valid_o    = 1'b0;
      w_err_accept = 1'b0;
      case (r_state)
         S_IDLE, S_DRAIN: begin
            if ((r_state == S_DRAIN) && !w_oc_zero) begin
               // Forwarded requests still in flight: hold the host off so
               // the error response cannot overtake a device response.
               w_state_nxt = S_DRAIN;
            end else if (a_valid_i && w_illegal) begin
               if (w_oc_zero) begin
                  a_ready_o    = 1'b1;
                  w_err_accept = 1'b1;
                  w_state_nxt  = S_RESP;
               end else begin
                  w_state_nxt  = S_DRAIN;
               end
            end else begin
               a_valid_o   = a_valid_i & w_room;
               a_ready_o   = a_ready_i & w_room;
               w_state_nxt = S_IDLE;
            end
         end
         S_RESP: begin
            if (err_d_ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Error response fields, latched at acceptance
   // -------------------------------------------------------------------------
   logic [IW-1:0]  r_d_source;
   logic [SZW-1:0] r_d_size;
   logic [2:0]     r_d_opcode;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_d_source <= '0;
         r_d_size   <= '0;
         r_d_opcode <= '0;
      end else if (w_err_accept) begin
         r_d_source <= a_source_i;
         r_d_size   <= a_size_i;
         // Get expects data back, so answer with AccessAckData
         r_d_opcode <= (a_opcode_i == c_op_get) ? 3'd1 : 3'd0;
      end
   end

   assign err_d_valid_o  = (r_state == S_RESP);
   assign err_d_error_o  = err_d_valid_o;
   assign err_d_opcode_o = r_d_opcode;
   assign err_d_source_o = r_d_source;
   assign err_d_size_o   = r_d_size;
   assign err_d_data_o   = '1;

   // -------------------------------------------------------------------------
   // Error statistics
   // -------------------------------------------------------------------------
`ifdef TLUL_ERR_CHK_STATS_EN
   logic [CntW-1:0] r_cnt;
   logic [AW-1:0]   r_err_addr;
   logic [2:0]      r_err_cause;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt       <= '0;
         r_err_addr  <= '0;
         r_err_cause <= '0;
      end else if (w_err_accept) begin
         // A count of zero means no error since the last clear, so this one
         // is the first; a simultaneous clear also makes it the first.
         if (err_clr_i || (r_cnt == '0)) begin
            r_err_addr  <= a_address_i;
            r_err_cause <= {w_opcode_bad, w_align_bad, w_mask_bad};
         end
         if (err_clr_i) begin
            r_cnt <= CntW'(1);
         end else if (!(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else if (err_clr_i) begin
         r_cnt       <= '0;
         r_err_addr  <= '0;
         r_err_cause <= '0;
      end
   end

   assign err_cnt_o   = r_cnt;
   assign err_addr_o  = r_err_addr;
   assign err_cause_o = r_err_cause;
`else
   logic w_unused_stats;

   assign err_cnt_o      = '0;
   assign err_addr_o     = '0;
   assign err_cause_o    = '0;
   // Address upper bits and the clear only feed the statistics block
   assign w_unused_stats = ^{err_clr_i, a_address_i};
`endif

endmodule
`default_nettype wire
